// File: rtl/cache_arbiter_if.sv
// Bus bundle between the I-cache, D-cache and the shared line-wide memory port.
// master: caches + memory side (drives requests, mem_rdata, mem_resp); slave: the arbiter.
interface cache_arbiter_if #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
  );

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates the single physical-memory port between I-cache fills and D-cache fills/write-backs.
// Optional macro CACHE_ARB_ROUND_ROBIN_EN: round-robin conflict resolution (default: D-cache wins).
module cache_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input logic           clk,
  input logic           rst,
  cache_arbiter_if.slave bus
);

  localparam int unsigned OFF = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT_I,
    S_GRANT_D,
    S_RESP,
    S_RELEASE
  } state_e;

  state_e            state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic              last_grant_q, last_grant_d;  // 1: D-cache was granted last
`endif

  logic d_req;
  logic grant_d;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFF], {OFF{1'b0}}};
  endfunction

  assign d_req = bus.d_read | bus.d_write;

  // Conflict resolution; a lone requester always wins.
  always_comb begin
    grant_d = d_req;
    if (bus.i_read && d_req) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      grant_d = ~last_grant_q;
`else
      grant_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      i_resp_q      <= 1'b0;
      d_resp_q      <= 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      last_grant_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      i_resp_q      <= i_resp_d;
      d_resp_q      <= d_resp_d;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      last_grant_q  <= last_grant_d;
`endif
    end
  end

  // Next-state and registered-output logic; resp pulses are set on mem_resp so they appear in RESP.
  always_comb begin
    state_d       = state_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    i_resp_d      = 1'b0;
    d_resp_d      = 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    last_grant_d  = last_grant_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_read || d_req) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
          last_grant_d = grant_d;
`endif
          if (grant_d) begin
            state_d       = S_GRANT_D;
            mem_write_d   = bus.d_write;
            mem_read_d    = ~bus.d_write;
            mem_address_d = line_align(bus.d_address);
            mem_wdata_d   = bus.d_wdata;
          end else begin
            state_d       = S_GRANT_I;
            mem_read_d    = 1'b1;
            mem_write_d   = 1'b0;
            mem_address_d = line_align(bus.i_address);
          end
        end
      end
      S_GRANT_I: begin
        if (bus.mem_resp) begin
          state_d     = S_RESP;
          i_rdata_d   = bus.mem_rdata;
          i_resp_d    = 1'b1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      S_GRANT_D: begin
        if (bus.mem_resp) begin
          state_d     = S_RESP;
          d_rdata_d   = bus.mem_rdata;
          d_resp_d    = 1'b1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      S_RESP:    state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.i_resp      = i_resp_q;
  assign bus.d_resp      = d_resp_q;

  // Simultaneous D-cache read and write is a caller bug; the write is the one served.
  a_no_d_rw: assert property (@(posedge clk) disable iff (rst) !(bus.d_read && bus.d_write))
    else $error("cache_arbiter: d_read and d_write asserted together");

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: a memory responder and a response monitor pop expectations.
module tb_cache_arbiter;

  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;

  typedef struct {
    logic          is_d;
    logic          chk_data;
    logic [LW-1:0] rdata;
  } resp_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } mem_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_mresp_cyc = -100;
  int   mem_lat = 3;
  logic mem_hold = 1'b0;
  logic force_resp = 1'b0;
  logic tb_last_d = 1'b0;

  resp_t exp_q[$];
  mem_t  mem_q[$];

  cache_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_i(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_v(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: checks each new strobe against mem_q, answers after mem_lat strobe cycles.
  initial begin : responder
    mem_t cur;
    logic busy;
    int   lat;
    busy = 1'b0;
    lat = 0;
    cur = '{wr: 1'b0, addr: '0, wdata: '0, rdata: '0};
    bus.mem_resp = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_resp = force_resp;
      if (busy && !(bus.mem_read === 1'b1 || bus.mem_write === 1'b1)) busy = 1'b0;
      if (!busy && (bus.mem_read === 1'b1 || bus.mem_write === 1'b1)) begin
        check_i("mem_op_expected", int'(mem_q.size() != 0), 1);
        if (mem_q.size() != 0) begin
          cur = mem_q.pop_front();
          check_i("mem_write", int'(bus.mem_write), int'(cur.wr));
          check_i("mem_read", int'(bus.mem_read), int'(!cur.wr));
          check_v("mem_address", LW'(bus.mem_address), LW'(cur.addr));
          if (cur.wr) check_v("mem_wdata", bus.mem_wdata, cur.wdata);
        end
        busy = 1'b1;
        lat = 1;
      end else if (busy) begin
        lat++;
      end
      if (busy && !mem_hold && lat >= mem_lat) begin
        bus.mem_resp = 1'b1;
        bus.mem_rdata = cur.rdata;
        last_mresp_cyc = cyc;
        busy = 1'b0;
      end
    end
  end

  // Response monitor: every resp pulse must match the head of exp_q.
  always @(negedge clk) begin
    resp_t e;
    if (bus.i_resp === 1'b1 || bus.d_resp === 1'b1) begin
      check_i("resp_onehot", int'(bus.i_resp && bus.d_resp), 0);
      check_i("resp_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_i("resp_who_d", int'(bus.d_resp), int'(e.is_d));
        check_i("resp_after_mem_resp", cyc - last_mresp_cyc, 1);
        if (e.chk_data) check_v("resp_rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
      end
    end
  end

  task automatic wait_any_resp(input string name, input int budget);
    int n;
    n = 0;
    while (!(bus.i_resp === 1'b1 || bus.d_resp === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_i({name, "_resp_seen"}, int'(bus.i_resp === 1'b1 || bus.d_resp === 1'b1), 1);
  endtask

  task automatic push_txn(input logic is_d, input logic wr, input logic [AW-1:0] addr,
                          input logic [LW-1:0] wdata, input logic [LW-1:0] rdata);
    mem_q.push_back('{wr: wr, addr: addr, wdata: wdata, rdata: rdata});
    exp_q.push_back('{is_d: is_d, chk_data: !wr, rdata: rdata});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [LW-1:0] line;
    logic          win;
    int            prev;
    rst = 1'b1;
    bus.i_read = 1'b0;
    bus.i_address = '0;
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
    bus.d_address = '0;
    bus.d_wdata = '0;

    // Reset with a pending I request, then the lone I fill.
    bus.i_read = 1'b1;
    bus.i_address = 32'h0000_1234;
    mem_lat = 5;
    push_txn(1'b0, 1'b0, 32'h0000_1220, '0, {32{8'hA5}});
    repeat (2) @(negedge clk);
    check_i("rst_i_resp", int'(bus.i_resp), 0);
    check_i("rst_d_resp", int'(bus.d_resp), 0);
    check_i("rst_mem_read", int'(bus.mem_read), 0);
    check_i("rst_mem_write", int'(bus.mem_write), 0);
    check_v("rst_mem_address", LW'(bus.mem_address), '0);
    check_v("rst_mem_wdata", bus.mem_wdata, '0);
    check_v("rst_i_rdata", bus.i_rdata, '0);
    check_v("rst_d_rdata", bus.d_rdata, '0);
    rst = 1'b0;
    @(negedge clk);
    check_i("grant_latency_mem_read", int'(bus.mem_read), 1);
    wait_any_resp("lone_i", 20);
    bus.i_read = 1'b0;
    repeat (2) @(negedge clk);

    // D write-back.
    mem_lat = 4;
    line = {8{32'hDEADBEEF}};
    push_txn(1'b1, 1'b1, 32'h8000_0040, line, '0);
    bus.d_write = 1'b1;
    bus.d_address = 32'h8000_0040;
    bus.d_wdata = line;
    wait_any_resp("d_wb", 20);
    bus.d_write = 1'b0;
    repeat (2) @(negedge clk);
    check_v("i_rdata_held", bus.i_rdata, {32{8'hA5}});

    // Abort a D fill with reset while memory holds its response.
    mem_hold = 1'b1;
    mem_q.push_back('{wr: 1'b0, addr: 32'h0000_3000, wdata: '0, rdata: '0});
    bus.d_read = 1'b1;
    bus.d_address = 32'h0000_3008;
    prev = 0;
    while (bus.mem_read !== 1'b1 && prev < 10) begin
      @(negedge clk);
      prev++;
    end
    check_i("abort_granted", int'(bus.mem_read), 1);
    @(negedge clk);
    rst = 1'b1;
    bus.d_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_i("abort_mem_read", int'(bus.mem_read), 0);
    check_i("abort_resp", int'(bus.i_resp | bus.d_resp), 0);
    force_resp = 1'b1;
    @(negedge clk);
    force_resp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_i("stray_mem_resp_resp", int'(bus.i_resp | bus.d_resp), 0);
      check_i("stray_mem_resp_strobe", int'(bus.mem_read | bus.mem_write), 0);
    end
    mem_hold = 1'b0;

    // Two conflicts right after reset (last_grant = I).
    mem_lat = 2;
    for (int r = 0; r < 2; r++) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      win = (r == 0);
`else
      win = 1'b1;
`endif
      tb_last_d = win;
      line = {8{32'h1100_0000 + 32'(r)}};
      push_txn(win, 1'b0, win ? 32'h0000_6040 : 32'h0000_7060, '0, line);
      @(negedge clk);
      bus.i_read = 1'b1;
      bus.d_read = 1'b1;
      bus.i_address = 32'h0000_7071;
      bus.d_address = 32'h0000_605F;
      wait_any_resp("conflict", 20);
      bus.i_read = 1'b0;
      bus.d_read = 1'b0;
      repeat (2) @(negedge clk);
    end

    // Both requesters held for 20 back-to-back transactions.
    mem_lat = 3;
    for (int k = 0; k < 20; k++) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      win = !tb_last_d;
`else
      win = 1'b1;
`endif
      tb_last_d = win;
      line = {8{32'h5A5A_0000 ^ 32'(k)}};
      push_txn(win, 1'b0, win ? 32'h0000_5020 : 32'h0000_4000, '0, line);
    end
    @(negedge clk);
    bus.i_read = 1'b1;
    bus.d_read = 1'b1;
    bus.i_address = 32'h0000_4010;
    bus.d_address = 32'h0000_5030;
    prev = 0;
    for (int k = 0; k < 20; k++) begin
      wait_any_resp("b2b", 12);
      if (k > 0) check_i("b2b_period", cyc - prev, 6);
      prev = cyc;
      @(negedge clk);
    end
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    repeat (4) @(negedge clk);
    check_i("queues_drained", exp_q.size() + mem_q.size(), 0);
    check_i("idle_strobe", int'(bus.mem_read | bus.mem_write), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
